// File: rtl/exp_request_ctrl_if.sv
// Request/handshake bundle between the exception request front end and CP0.
// The master side drives raw lines, ack, eret and mask; the slave presents requests.
interface exp_request_ctrl_if;
  logic [2:0] irq_in;
  logic       ack;
  logic       is_eret;
  logic [2:0] block_mask;
  logic [2:0] exp_src;
  logic [2:0] pending;
  logic       busy;
  logic [1:0] cur_id;

  modport master (
    output irq_in, ack, is_eret, block_mask,
    input  exp_src, pending, busy, cur_id
  );

  modport slave (
    input  irq_in, ack, is_eret, block_mask,
    output exp_src, pending, busy, cur_id
  );
endinterface

// File: rtl/exp_request_ctrl.sv
// Exception request front end: synchronise, debounce and edge-detect three raw
// request lines, then present one pending request at a time to CP0.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | nothing presented; pick lowest eligible pending line
// ST_ASSERT  | exp_src held one-hot for cur_id until ack or mask
// ST_SERVICE | CP0 took the request; wait for eret before the next one
module exp_request_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_BITS   = 3
) (
  input logic              clk,
  input logic              clr,
  exp_request_ctrl_if.slave bus
);

  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);
  localparam logic [1:0]          ID_NONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [2:0]          s1, s2, filt, filt_d;
  logic [DEB_BITS-1:0] cnt [3];
  logic [2:0]          rise;
  logic [2:0]          pending_q, pend_clr;
  logic [2:0]          eligible;
  logic [1:0]          sel;
  logic [2:0]          exp_src_q, exp_src_n;
  logic [1:0]          cur_id_q, cur_id_n;

  // Synchroniser, debounce filter and edge-detect history
  always_ff @(posedge clk) begin
    if (clr) begin
      s1     <= '0;
      s2     <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1     <= bus.irq_in;
      s2     <= s1;
      filt_d <= filt;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_BITS'(1);
        end
      end
    end
  end

  assign rise = filt & ~filt_d;

  // A rise landing on the same edge as its ack keeps the bit set
  always_ff @(posedge clk) begin
    if (clr) pending_q <= '0;
    else     pending_q <= (pending_q & ~pend_clr) | rise;
  end

  assign eligible = pending_q & ~bus.block_mask;

  always_comb begin
    sel = 2'd0;
    if (eligible[0])      sel = 2'd0;
    else if (eligible[1]) sel = 2'd1;
    else if (eligible[2]) sel = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      exp_src_q <= '0;
      cur_id_q  <= ID_NONE;
    end else begin
      state     <= state_n;
      exp_src_q <= exp_src_n;
      cur_id_q  <= cur_id_n;
    end
  end

  always_comb begin
    state_n   = state;
    exp_src_n = exp_src_q;
    cur_id_n  = cur_id_q;
    pend_clr  = '0;
    case (state)
      ST_IDLE: begin
        exp_src_n = '0;
        if (|eligible) begin
          exp_src_n = 3'b001 << sel;
          cur_id_n  = sel;
          state_n   = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (bus.ack) begin
          pend_clr  = 3'b001 << cur_id_q;
          exp_src_n = '0;
          state_n   = ST_SERVICE;
        end else if (|(bus.block_mask & exp_src_q)) begin
          // exp_src_q is one-hot on cur_id, so this tests block_mask[cur_id]
          exp_src_n = '0;
          cur_id_n  = ID_NONE;
          state_n   = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        exp_src_n = '0;
        if (bus.is_eret) begin
          cur_id_n = ID_NONE;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        exp_src_n = '0;
        cur_id_n  = ID_NONE;
        state_n   = ST_IDLE;
      end
    endcase
  end

  assign bus.exp_src = exp_src_q;
  assign bus.pending = pending_q;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.cur_id  = cur_id_q;

endmodule

// File: tb/tb_exp_request_ctrl.sv
// Directed bench for exp_request_ctrl: a vector table for the basic request
// flow and glitch filtering, plus hand sequences for priority, mask and collisions.
module tb_exp_request_ctrl;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  exp_request_ctrl_if bus ();

  exp_request_ctrl #(.DEB_CYCLES(4), .DEB_BITS(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] irq;
    logic       ack;
    logic       eret;
    logic [2:0] mask;
    int         n;
    logic [2:0] e_src;
    logic [2:0] e_pend;
    logic       e_busy;
    logic [1:0] e_cur;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic [2:0] irq, logic ack, logic eret, logic [2:0] mask, int n,
                              logic [2:0] e_src, logic [2:0] e_pend, logic e_busy, logic [1:0] e_cur);
    vec_t v;
    v.irq = irq; v.ack = ack; v.eret = eret; v.mask = mask; v.n = n;
    v.e_src = e_src; v.e_pend = e_pend; v.e_busy = e_busy; v.e_cur = e_cur;
    return v;
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] irq, input logic ack, input logic eret, input logic [2:0] mask);
    bus.irq_in     = irq;
    bus.ack        = ack;
    bus.is_eret    = eret;
    bus.block_mask = mask;
  endtask

  task automatic check(input string name, input logic [2:0] e_src, input logic [2:0] e_pend,
                       input logic e_busy, input logic [1:0] e_cur);
    checks++;
    if (bus.exp_src !== e_src || bus.pending !== e_pend || bus.busy !== e_busy || bus.cur_id !== e_cur) begin
      failures++;
      $display("FAIL %s: got src=%b pend=%b busy=%b cur=%0d, want src=%b pend=%b busy=%b cur=%0d",
               name, bus.exp_src, bus.pending, bus.busy, bus.cur_id, e_src, e_pend, e_busy, e_cur);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // single request on line 1, then glitch rejection and a minimum-length pulse on line 0
    vecs[0]  = mk(3'b010, 0, 0, 3'b000, 6, 3'b000, 3'b000, 0, 2'd3);
    vecs[1]  = mk(3'b010, 0, 0, 3'b000, 1, 3'b000, 3'b010, 0, 2'd3);
    vecs[2]  = mk(3'b010, 0, 0, 3'b000, 1, 3'b010, 3'b010, 1, 2'd1);
    vecs[3]  = mk(3'b010, 1, 0, 3'b000, 1, 3'b000, 3'b000, 1, 2'd1);
    vecs[4]  = mk(3'b010, 0, 0, 3'b000, 3, 3'b000, 3'b000, 1, 2'd1);
    vecs[5]  = mk(3'b010, 0, 1, 3'b000, 1, 3'b000, 3'b000, 0, 2'd3);
    vecs[6]  = mk(3'b000, 1, 0, 3'b000, 8, 3'b000, 3'b000, 0, 2'd3);
    vecs[7]  = mk(3'b001, 0, 0, 3'b000, 3, 3'b000, 3'b000, 0, 2'd3);
    vecs[8]  = mk(3'b000, 0, 0, 3'b000, 8, 3'b000, 3'b000, 0, 2'd3);
    vecs[9]  = mk(3'b001, 0, 0, 3'b000, 4, 3'b000, 3'b000, 0, 2'd3);
    vecs[10] = mk(3'b000, 0, 0, 3'b000, 2, 3'b000, 3'b000, 0, 2'd3);
    vecs[11] = mk(3'b000, 0, 0, 3'b000, 1, 3'b000, 3'b001, 0, 2'd3);
    vecs[12] = mk(3'b000, 0, 1, 3'b000, 1, 3'b001, 3'b001, 1, 2'd0);
    vecs[13] = mk(3'b000, 1, 0, 3'b000, 1, 3'b000, 3'b000, 1, 2'd0);
    vecs[14] = mk(3'b000, 0, 1, 3'b000, 1, 3'b000, 3'b000, 0, 2'd3);
    vecs[15] = mk(3'b000, 0, 0, 3'b000, 8, 3'b000, 3'b000, 0, 2'd3);

    // reset with all lines high, then release
    clr = 1'b1;
    drive(3'b111, 0, 0, 3'b000);
    step(2);
    check("reset_hold", 3'b000, 3'b000, 0, 2'd3);
    clr = 1'b0;
    step(6);
    check("post_reset_e5", 3'b000, 3'b000, 0, 2'd3);
    step(1);
    check("post_reset_e6", 3'b000, 3'b111, 0, 2'd3);
    step(1);
    check("post_reset_e7", 3'b001, 3'b111, 1, 2'd0);

    // reset in the middle of ASSERT clears everything
    clr = 1'b1;
    drive(3'b000, 0, 0, 3'b000);
    step(2);
    check("reset_mid_op", 3'b000, 3'b000, 0, 2'd3);
    clr = 1'b0;
    step(8);
    check("reset_settle", 3'b000, 3'b000, 0, 2'd3);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].irq, vecs[i].ack, vecs[i].eret, vecs[i].mask);
      step(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].e_src, vecs[i].e_pend, vecs[i].e_busy, vecs[i].e_cur);
    end

    // priority: lines 0 and 2 together
    drive(3'b101, 0, 0, 3'b000);
    step(8);
    check("prio_first", 3'b001, 3'b101, 1, 2'd0);
    drive(3'b101, 1, 0, 3'b000);
    step(1);
    check("prio_ack0", 3'b000, 3'b100, 1, 2'd0);
    drive(3'b101, 0, 1, 3'b000);
    step(1);
    check("prio_eret0", 3'b000, 3'b100, 0, 2'd3);
    drive(3'b101, 0, 0, 3'b000);
    step(1);
    check("prio_second", 3'b100, 3'b100, 1, 2'd2);
    drive(3'b101, 0, 1, 3'b000);
    step(1);
    check("eret_in_assert", 3'b100, 3'b100, 1, 2'd2);
    // new rise on line 0 while line 2 is presented: no pre-emption
    drive(3'b100, 0, 0, 3'b000);
    step(8);
    drive(3'b101, 0, 0, 3'b000);
    step(7);
    check("no_preempt", 3'b100, 3'b101, 1, 2'd2);
    drive(3'b101, 1, 0, 3'b000);
    step(1);
    check("prio_ack2", 3'b000, 3'b001, 1, 2'd2);
    drive(3'b101, 0, 1, 3'b000);
    step(1);
    drive(3'b101, 0, 0, 3'b000);
    step(1);
    check("prio_third", 3'b001, 3'b001, 1, 2'd0);
    drive(3'b101, 1, 0, 3'b000);
    step(1);
    drive(3'b000, 0, 1, 3'b000);
    step(1);
    drive(3'b000, 0, 0, 3'b000);
    step(8);
    check("prio_done", 3'b000, 3'b000, 0, 2'd3);

    // masking
    drive(3'b011, 0, 0, 3'b001);
    step(8);
    check("mask_select", 3'b010, 3'b011, 1, 2'd1);
    drive(3'b011, 0, 0, 3'b011);
    step(1);
    check("mask_withdraw", 3'b000, 3'b011, 0, 2'd3);
    step(1);
    check("mask_all_idle", 3'b000, 3'b011, 0, 2'd3);
    drive(3'b011, 0, 0, 3'b000);
    step(1);
    check("mask_release", 3'b001, 3'b011, 1, 2'd0);
    drive(3'b011, 1, 0, 3'b000);
    step(1);
    drive(3'b011, 0, 1, 3'b000);
    step(1);
    drive(3'b011, 0, 0, 3'b000);
    step(1);
    check("mask_line1", 3'b010, 3'b010, 1, 2'd1);
    drive(3'b011, 1, 0, 3'b000);
    step(1);
    drive(3'b000, 0, 1, 3'b000);
    step(1);
    drive(3'b000, 0, 0, 3'b000);
    step(8);
    check("mask_done", 3'b000, 3'b000, 0, 2'd3);

    // collision: new rise on line 1 on the same edge as its ack
    drive(3'b010, 0, 0, 3'b000);
    step(8);
    check("coll_present", 3'b010, 3'b010, 1, 2'd1);
    drive(3'b000, 0, 0, 3'b000);
    step(8);
    drive(3'b010, 0, 0, 3'b000);
    step(6);
    drive(3'b010, 1, 0, 3'b000);
    step(1);
    check("coll_set_wins", 3'b000, 3'b010, 1, 2'd1);
    drive(3'b010, 0, 1, 3'b000);
    step(1);
    drive(3'b010, 0, 0, 3'b000);
    step(1);
    check("coll_represent", 3'b010, 3'b010, 1, 2'd1);
    // ack and eret together in ASSERT: ack wins
    drive(3'b010, 1, 1, 3'b000);
    step(1);
    check("ack_eret_same", 3'b000, 3'b000, 1, 2'd1);
    drive(3'b010, 0, 0, 3'b000);
    step(2);
    check("service_waits", 3'b000, 3'b000, 1, 2'd1);
    drive(3'b010, 0, 1, 3'b000);
    step(1);
    check("final_eret", 3'b000, 3'b000, 0, 2'd3);
    drive(3'b000, 0, 0, 3'b000);
    step(8);
    check("final_idle", 3'b000, 3'b000, 0, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp_request_ctrl.md
Name: exp_request_ctrl

Overview:
- Front end for the CP0 exception block's three exception-source inputs (ExpSrc0..2).
- Synchronises, debounces and edge-detects three raw external request lines (buttons/peripherals) and latches each rising edge as a pending request.
- Presents exactly one request at a time as a held one-hot level until CP0 takes it (ack), then waits for eret before presenting the next.
- Line 0 has the highest priority; line 2 the lowest.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronised input must differ from the filtered value before the filtered value flips (range 1..2^DEB_BITS-1).
DEB_BITS, 3, width of each per-line debounce counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
clr  input  1  reset, synchronous, active-high.
irq_in  input  3  raw asynchronous request lines; bit i maps to ExpSrc i.
ack  input  1  CP0 exception-taken indication, sampled at the rising edge.
is_eret  input  1  an eret instruction is completing this cycle.
block_mask  input  3  CP0 Block register bits [2:0]; a 1 masks that line.
exp_src  output  3  registered one-hot (or zero) request to CP0 ExpSrc2..0.
pending  output  3  latched, not-yet-serviced requests.
busy  output  1  high when state is not IDLE.
cur_id  output  2  index of the line presented or in service; 3 when none.

Behaviour:
- Reset (clr=1 at an edge, mid-operation included): sync flops, filtered values, edge flops, debounce counters, pending, exp_src = 0; state = IDLE; busy = 0; cur_id = 3. No request survives reset.
- Synchroniser: two flops per line: s1 <= irq_in, s2 <= s1.
- Debounce, per line:
  - If s2 == filt, cnt <= 0.
  - Else, if cnt == DEB_CYCLES-1, filt <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
  - filt therefore flips exactly DEB_CYCLES edges after s2 changes, provided s2 is stable throughout. Shorter pulses never reach filt.
- Edge detect: filt_d <= filt. A rise is filt & ~filt_d, which sets pending[i] at the next edge. Falling edges are ignored.
- Eligible set: pending & ~block_mask. Selection is the lowest eligible index.
- FSM, three states:
  - IDLE:
    - If the eligible set is nonzero: exp_src <= onehot(sel), cur_id <= sel, go to ASSERT.
    - Otherwise exp_src stays 0.
  - ASSERT (exp_src held constant):
    - On ack: pending[cur_id] cleared, exp_src <= 0, go to SERVICE.
    - Else, if block_mask[cur_id]=1: exp_src <= 0, cur_id <= 3, go to IDLE. pending[cur_id] is kept.
    - A higher-priority request arriving during ASSERT does not pre-empt the presented request.
  - SERVICE:
    - exp_src = 0; cur_id keeps the serviced line.
    - On is_eret: cur_id <= 3, go to IDLE.
    - New edges still set pending bits.
- Simultaneous events:
  - Set and clear of the same pending bit in one cycle: set wins, so the bit stays 1 and the request re-presents later.
  - ack and is_eret in the same ASSERT cycle: ack wins and is_eret is ignored.
  - is_eret in IDLE or ASSERT: no effect.
  - ack in IDLE or SERVICE: no effect.
- Latency (DEB_CYCLES=4, idle FSM): irq_in first sampled high at edge E0 gives s2=1 at E1, filt=1 at E5, pending at E6, exp_src at E7. General formula: 3+DEB_CYCLES edges after E0.
- exp_src is never multi-hot. Minimum gap between two serviced requests is one IDLE cycle after eret.

Test Plan:
- Reset: hold clr 2 cycles with irq_in=3'b111 → exp_src=0, pending=0, busy=0, cur_id=3; after clr drops, line 0 presents at E7 relative to the first post-reset edge.
- Single request: irq_in[1] goes high and stays high → exp_src=3'b010 exactly 7 edges later, cur_id=1. ack 1 cycle → exp_src=0, pending[1]=0, busy=1. is_eret → busy=0, cur_id=3.
- Glitch rejection: irq_in[0] high for 3 cycles, then low → pending stays 0 and exp_src stays 0 throughout. A 4-cycle pulse → pending[0]=1.
- Priority and no pre-emption: lines 2 and 0 rise in the same cycle → exp_src=3'b001. After ack+eret → exp_src=3'b100. Line 0 rising while line 2 is in ASSERT → exp_src stays 3'b100.
- Masking: pending=3'b011 with block_mask=3'b001 → exp_src=3'b010. Set block_mask[1] while it is presented → back to IDLE, exp_src=0, pending stays 3'b011.
- Collisions: a new edge on line 1 in the same cycle as ack of line 1 → pending[1] stays 1 and re-presents after eret. ack and is_eret together in ASSERT → FSM goes to SERVICE, not IDLE.
